yarp_mem_arbiter: RTL

Two-requester memory arbiter that shares one external memory port between the YARP instruction-fetch path and the load/store path. It sits between the fetch and data-memory units on one side and the single memory bus on the other side. It serialises requests with one outstanding transaction at a time and routes each response back to its owner. Priority is fixed (data first) or round-robin, selected at compile time.

---
 rtl/yarp_mem_arbiter.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/yarp_mem_arbiter.sv
// Shares one memory port between instruction fetch and load/store, one transaction in flight.
// Define YARP_MEM_ARB_RR_EN for round-robin tie-breaking; otherwise data always wins ties.
module yarp_mem_arbiter (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic        if_gnt_o,
    output logic        if_rvalid_o,
    output logic [31:0] if_rdata_o,
    input  logic        d_req_i,
    input  logic [31:0] d_addr_i,
    input  logic [1:0]  d_byte_en_i,
    input  logic        d_wr_i,
    input  logic [31:0] d_wr_data_i,
    output logic        d_gnt_o,
    output logic        d_rvalid_o,
    output logic [31:0] d_rdata_o,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    output logic [1:0]  mem_byte_en_o,
    output logic        mem_wr_o,
    output logic [31:0] mem_wr_data_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    output logic        busy_o
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] RSP  = 2'd2;

    localparam logic OWNER_IF = 1'b0;
    localparam logic OWNER_D  = 1'b1;

    logic [1:0]  state_r;
    logic [1:0]  state_nxt_s;
    logic        owner_r;
    logic        owner_nxt_s;
    logic        last_owner_r;
    logic        last_owner_nxt_s;
    logic        mem_req_r;
    logic        mem_req_nxt_s;
    logic [31:0] mem_addr_r;
    logic [31:0] mem_addr_nxt_s;
    logic [1:0]  mem_byte_en_r;
    logic [1:0]  mem_byte_en_nxt_s;
    logic        mem_wr_r;
    logic        mem_wr_nxt_s;
    logic [31:0] mem_wr_data_r;
    logic [31:0] mem_wr_data_nxt_s;
    logic        busy_r;
    logic        busy_nxt_s;

    logic        gnt_s;
    logic        rsp_s;
    logic        launch_s;
    logic        pick_d_s;

    // Protocol events: grant in REQ, response in RSP, and whether a new transaction starts now
    always_comb begin
        gnt_s    = (state_r == REQ) & mem_gnt_i;
        rsp_s    = (state_r == RSP) & mem_rvalid_i;
        launch_s = ((state_r == IDLE) | rsp_s) & (if_req_i | d_req_i);
    end

`ifdef YARP_MEM_ARB_RR_EN
    logic prev_owner_s;

    // Round-robin winner; a completing response already counts as the latest service
    always_comb begin
        if (state_r == RSP) begin
            prev_owner_s = owner_r;
        end else begin
            prev_owner_s = last_owner_r;
        end
        pick_d_s = d_req_i & (~if_req_i | (prev_owner_s == OWNER_IF));
    end
`else
    // Fixed priority winner: data beats fetch whenever it is requesting
    always_comb begin
        pick_d_s = d_req_i;
    end
`endif

    // Next FSM state
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (launch_s) begin
                    state_nxt_s = REQ;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            REQ: begin
                if (mem_gnt_i) begin
                    state_nxt_s = RSP;
                end else begin
                    state_nxt_s = REQ;
                end
            end
            RSP: begin
                if (launch_s) begin
                    state_nxt_s = REQ;
                end else if (mem_rvalid_i) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = RSP;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Latch the winner's fields on launch; drop the memory request once it is granted
    always_comb begin
        owner_nxt_s       = owner_r;
        mem_req_nxt_s     = mem_req_r;
        mem_addr_nxt_s    = mem_addr_r;
        mem_byte_en_nxt_s = mem_byte_en_r;
        mem_wr_nxt_s      = mem_wr_r;
        mem_wr_data_nxt_s = mem_wr_data_r;
        if (launch_s) begin
            mem_req_nxt_s = 1'b1;
            if (pick_d_s) begin
                owner_nxt_s       = OWNER_D;
                mem_addr_nxt_s    = d_addr_i;
                mem_byte_en_nxt_s = d_byte_en_i;
                mem_wr_nxt_s      = d_wr_i;
                mem_wr_data_nxt_s = d_wr_data_i;
            end else begin
                owner_nxt_s       = OWNER_IF;
                mem_addr_nxt_s    = if_addr_i;
                mem_byte_en_nxt_s = 2'b11;
                mem_wr_nxt_s      = 1'b0;
                mem_wr_data_nxt_s = 32'd0;
            end
        end else if (gnt_s) begin
            mem_req_nxt_s = 1'b0;
        end else begin
            mem_req_nxt_s = mem_req_r;
        end
    end

    // History of the last completed owner and the busy flag
    always_comb begin
        if (rsp_s) begin
            last_owner_nxt_s = owner_r;
        end else begin
            last_owner_nxt_s = last_owner_r;
        end
        busy_nxt_s = (state_nxt_s != IDLE);
    end

    // State and registered memory-side outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r       <= IDLE;
            owner_r       <= OWNER_IF;
            last_owner_r  <= OWNER_IF;
            mem_req_r     <= 1'b0;
            mem_addr_r    <= 32'd0;
            mem_byte_en_r <= 2'b00;
            mem_wr_r      <= 1'b0;
            mem_wr_data_r <= 32'd0;
            busy_r        <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            owner_r       <= owner_nxt_s;
            last_owner_r  <= last_owner_nxt_s;
            mem_req_r     <= mem_req_nxt_s;
            mem_addr_r    <= mem_addr_nxt_s;
            mem_byte_en_r <= mem_byte_en_nxt_s;
            mem_wr_r      <= mem_wr_nxt_s;
            mem_wr_data_r <= mem_wr_data_nxt_s;
            busy_r        <= busy_nxt_s;
        end
    end

    assign mem_req_o     = mem_req_r;
    assign mem_addr_o    = mem_addr_r;
    assign mem_byte_en_o = mem_byte_en_r;
    assign mem_wr_o      = mem_wr_r;
    assign mem_wr_data_o = mem_wr_data_r;
    assign busy_o        = busy_r;

    // Grant and response steering to the owner only; the other side sees zeros
    assign if_gnt_o    = gnt_s & (owner_r == OWNER_IF);
    assign d_gnt_o     = gnt_s & (owner_r == OWNER_D);
    assign if_rvalid_o = rsp_s & (owner_r == OWNER_IF);
    assign d_rvalid_o  = rsp_s & (owner_r == OWNER_D);
    assign if_rdata_o  = if_rvalid_o ? mem_rdata_i : 32'd0;
    assign d_rdata_o   = d_rvalid_o ? mem_rdata_i : 32'd0;

endmodule
